// File: rtl/vector_pkg.sv
// Shared definitions for the vector write-back and read-side sequencers.
//   - Element/register geometry constants.
//   - Write-back FSM state encoding.
//   - norm_vl(): maps a raw vector length onto the length actually executed.
package vector_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_VREG = 8;
  localparam int ADDR_W   = 6;
  localparam int VL_W     = 7;
  localparam int LAT_W    = 4;
  localparam int MAX_VL   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } wr_state_e;

  // A length of zero, or anything beyond the register depth, means a full register.
  function automatic logic [VL_W-1:0] norm_vl(input logic [VL_W-1:0] raw);
    logic [VL_W-1:0] eff;
    if ((raw == 7'd0) || (raw > 7'd64)) begin
      eff = 7'd64;
    end else begin
      eff = raw;
    end
    return eff;
  endfunction

endpackage

// File: rtl/vreg_onehot_decode.sv
// Vector register number to one-hot register-file write-enable decoder.
// Ports:
//   vreg_i   : 3-bit destination register number
//   onehot_o : NUM_VREG-bit one-hot select
module vreg_onehot_decode #(
  parameter int NUM_VREG = 8
) (
  input  logic [2:0]          vreg_i,
  output logic [NUM_VREG-1:0] onehot_o
);

  // Compare every register slot against the requested number.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_VREG; i++) begin
      onehot_o[i] = (vreg_i == 3'(i));
    end
  end

endmodule

// File: rtl/vector_result_writer.sv
// Write-back end of a vector functional unit result stream.
// After issue it waits out the unit's functional time, then writes one result
// per clock into the destination register at element addresses 0..VL-1 and
// publishes a running committed-element count for chaining.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : issue pulse (only honoured when idle)
//   i_vl, i_i         : raw vector length, destination register number
//   i_latency         : cycles from issue to element 0 valid on i_fu_data
//   i_fu_data         : functional unit result stream
//   o_we/o_waddr/o_wdata : register file write port (o_we one-hot)
//   o_elem_count      : elements committed in the current operation
//   o_busy, o_done    : operation outstanding / completion pulse
//   o_start_ignored   : pulse when an issue arrives while busy
module vector_result_writer #(
  parameter int DATA_W   = 64,
  parameter int NUM_VREG = 8,
  parameter int ADDR_W   = 6,
  parameter int VL_W     = 7,
  parameter int LAT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [VL_W-1:0]     i_vl,
  input  logic [2:0]          i_i,
  input  logic [LAT_W-1:0]    i_latency,
  input  logic [DATA_W-1:0]   i_fu_data,
  output logic [NUM_VREG-1:0] o_we,
  output logic [ADDR_W-1:0]   o_waddr,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [VL_W-1:0]     o_elem_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_start_ignored
);

  import vector_pkg::*;

  wr_state_e state_q, state_d;

  logic [LAT_W-1:0]    wait_q, wait_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic [VL_W-1:0]     idx_q, idx_d;
  logic [VL_W-1:0]     cnt_q, cnt_d;
  logic [2:0]          vreg_q, vreg_d;
  logic [NUM_VREG-1:0] we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ign_q, ign_d;
  logic                last_q, last_d;

  logic [NUM_VREG-1:0] onehot_s;
  logic                accept_s;
  logic                capture_s;
  logic                final_s;
  logic [VL_W-1:0]     idx_inc_s;

  vreg_onehot_decode #(
    .NUM_VREG (NUM_VREG)
  ) u_vreg_dec (
    .vreg_i   (vreg_q),
    .onehot_o (onehot_s)
  );

  // The final write is presented while the FSM is already IDLE; busy_q still
  // covers that cycle, so a start there is treated as arriving while busy.
  assign accept_s  = i_start && (state_q == ST_IDLE) && !busy_q;
  // Element 0 is sampled in the last WAIT cycle, later elements in WRITE.
  assign capture_s = ((state_q == ST_WAIT) && (wait_q == '0)) || (state_q == ST_WRITE);
  assign idx_inc_s = idx_q + VL_W'(1);
  assign final_s   = capture_s && (idx_inc_s == vl_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q != '0) begin
          state_d = ST_WAIT;
        end else if (final_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (final_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    wait_d  = wait_q;
    vl_d    = vl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vreg_d  = vreg_q;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = last_q;
    ign_d   = i_start && !accept_s;
    last_d  = final_s;

    if (accept_s) begin
      vreg_d = i_i;
      vl_d   = norm_vl(i_vl);
      idx_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      // A zero functional time behaves as one cycle.
      if (i_latency == '0) begin
        wait_d = '0;
      end else begin
        wait_d = i_latency - LAT_W'(1);
      end
    end else if (last_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    if ((state_q == ST_WAIT) && (wait_q != '0)) begin
      wait_d = wait_q - LAT_W'(1);
    end else begin
      wait_d = wait_d;
    end

    if (capture_s) begin
      we_d    = onehot_s;
      waddr_d = idx_q[ADDR_W-1:0];
      wdata_d = i_fu_data;
      idx_d   = idx_inc_s;
      cnt_d   = idx_inc_s;
    end else begin
      we_d    = '0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      vl_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vreg_q  <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ign_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      vl_q    <= vl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vreg_q  <= vreg_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ign_q   <= ign_d;
      last_q  <= last_d;
    end
  end

  assign o_we            = we_q;
  assign o_waddr         = waddr_q;
  assign o_wdata         = wdata_q;
  assign o_elem_count    = cnt_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_start_ignored = ign_q;

endmodule

// File: tb/tb_vector_result_writer.sv
// Randomized scoreboard bench for vector_result_writer.
module tb_vector_result_writer;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [6:0]  i_vl;
  logic [2:0]  i_i;
  logic [3:0]  i_latency;
  logic [63:0] i_fu_data;
  logic [7:0]  o_we;
  logic [5:0]  o_waddr;
  logic [63:0] o_wdata;
  logic [6:0]  o_elem_count;
  logic        o_busy;
  logic        o_done;
  logic        o_start_ignored;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic [31:0] salt = 32'h0;

  vector_result_writer dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_vl            (i_vl),
    .i_i             (i_i),
    .i_latency       (i_latency),
    .i_fu_data       (i_fu_data),
    .o_we            (o_we),
    .o_waddr         (o_waddr),
    .o_wdata         (o_wdata),
    .o_elem_count    (o_elem_count),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_start_ignored (o_start_ignored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result stream: a unique word per cycle, so each write's source cycle is identifiable.
  assign i_fu_data = {salt, 32'(cyc)};

  // ---------------- reference model ----------------
  typedef struct {
    int          c;
    logic [7:0]  we;
    logic [5:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  iq[$];

  bit op_valid = 1'b0;
  int t0 = 0, m_lat = 0, m_vl = 0, done_c = 0, cnt_before = 0;

  function automatic int exp_count(int c);
    int n;
    if (!op_valid) return 0;
    if (c <= t0) return cnt_before;
    n = c - t0 - m_lat;
    if (n < 0) n = 0;
    if (n > m_vl) n = m_vl;
    return n;
  endfunction

  function automatic bit exp_busy(int c);
    return op_valid && (c > t0) && (c < done_c);
  endfunction

  task automatic model_start(int c, int vl_raw, int vreg, int lat_raw);
    int ev, el;
    logic [7:0] oh;
    wr_t w;
    ev = ((vl_raw == 0) || (vl_raw > 64)) ? 64 : vl_raw;
    el = (lat_raw == 0) ? 1 : lat_raw;
    if (!op_valid || (c >= done_c)) begin
      cnt_before = exp_count(c);
      op_valid = 1'b1;
      t0 = c; m_lat = el; m_vl = ev; done_c = c + el + ev + 1;
      oh = 8'd1;
      oh = oh << vreg;
      for (int k = 0; k < ev; k++) begin
        w.c = c + el + k + 1;
        w.we = oh;
        w.addr = 6'(k);
        w.data = {salt, 32'(c + el + k)};
        wq.push_back(w);
      end
      dq.push_back(done_c);
    end else begin
      iq.push_back(c + 1);
    end
  endtask

  task automatic model_reset();
    op_valid = 1'b0;
    wq.delete();
    dq.delete();
    iq.delete();
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      while (wq.size() > 0 && wq[0].c < cyc) begin
        e = wq.pop_front();
        chk("we_missed", 64'(0), 64'(e.we));
      end
      if (wq.size() > 0 && wq[0].c == cyc) begin
        e = wq.pop_front();
        chk("we", 64'(o_we), 64'(e.we));
        chk("waddr", 64'(o_waddr), 64'(e.addr));
        chk("wdata", o_wdata, e.data);
      end else begin
        chk("we_idle", 64'(o_we), 64'(0));
      end
      while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
      if (dq.size() > 0 && dq[0] == cyc) begin
        void'(dq.pop_front());
        chk("done", 64'(o_done), 64'(1));
      end else begin
        chk("done_idle", 64'(o_done), 64'(0));
      end
      while (iq.size() > 0 && iq[0] < cyc) void'(iq.pop_front());
      if (iq.size() > 0 && iq[0] == cyc) begin
        void'(iq.pop_front());
        chk("start_ignored", 64'(o_start_ignored), 64'(1));
      end else begin
        chk("start_ignored_idle", 64'(o_start_ignored), 64'(0));
      end
      chk("busy", 64'(o_busy), 64'(exp_busy(cyc)));
      chk("elem_count", 64'(o_elem_count), 64'(exp_count(cyc)));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    // Operand inputs wander every cycle; only values sampled with i_start matter.
    i_vl      = 7'($urandom);
    i_i       = 3'($urandom);
    i_latency = 4'($urandom);
  endtask

  task automatic start_op(int vl, int vreg, int lat);
    i_start   = 1'b1;
    i_vl      = 7'(vl);
    i_i       = 3'(vreg);
    i_latency = 4'(lat);
    model_start(cyc, vl, vreg, lat);
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_until(int c);
    int n = 0;
    while ((cyc < c) && (n < 500)) begin
      step();
      n++;
    end
  endtask

  task automatic idle_wait();
    int n = 0;
    while (op_valid && (cyc < done_c) && (n < 400)) begin
      step();
      n++;
    end
    if (n >= 400) chk("idle_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int t, r, vl;
    salt      = $urandom;
    rst       = 1'b1;
    i_start   = 1'b0;
    i_vl      = 7'd0;
    i_i       = 3'd0;
    i_latency = 4'd0;
    step(); step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Basic operation.
    start_op(8, 3, 4);
    idle_wait();
    step(); step();

    // Start while busy is dropped.
    t = cyc;
    start_op(8, 3, 4);
    wait_until(t + 6);
    start_op(5, 1, 2);
    idle_wait();
    step();

    // Length/latency normalisation.
    start_op(0, 2, 0);
    idle_wait();
    start_op(100, 6, 7);
    idle_wait();
    step();

    // Back-to-back: issue in the done cycle.
    start_op(8, 3, 4);
    wait_until(done_c);
    start_op(2, 5, 1);
    idle_wait();
    step();

    // Reset mid-operation, then a fresh operation.
    t = cyc;
    start_op(8, 3, 4);
    wait_until(t + 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("waddr_after_rst", 64'(o_waddr), 64'(0));
    chk("wdata_after_rst", o_wdata, 64'(0));
    step();
    start_op(8, 3, 4);
    idle_wait();
    step();

    // Randomized traffic, including starts that land while busy.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      vl = (r == 0) ? $urandom_range(0, 127) : $urandom_range(1, 12);
      if ($urandom_range(0, 2) == 0) idle_wait();
      start_op(vl, $urandom_range(0, 7), $urandom_range(0, 15));
      repeat ($urandom_range(0, 4)) step();
    end
    idle_wait();
    step(); step(); step();

    chk("write_queue_drained", 64'(wq.size()), 64'(0));
    chk("done_queue_drained", 64'(dq.size()), 64'(0));
    chk("ignore_queue_drained", 64'(iq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_result_writer.md
Name: vector_result_writer

Overview:
- Write-back end of a vector functional unit result stream.
- On issue, captures the destination register Vi, the vector length and the unit's functional time.
- Waits out the functional time, then writes one 64-bit result per clock into Vi at element addresses 0..VL-1.
- Publishes a running committed-element count for chaining, plus busy and done status to the issue logic.

Parameters:
- DATA_W, 64, element width.
- NUM_VREG, 8, number of vector registers; o_we is one-hot across them.
- ADDR_W, 6, element address width (64 elements).
- VL_W, 7, vector length width.
- LAT_W, 4, functional-time field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  issue pulse; sampled only in IDLE.
- i_vl  in  VL_W  vector length.
- i_i  in  3  destination vector register number.
- i_latency  in  LAT_W  cycles from the i_start cycle to the cycle element 0 is valid on i_fu_data.
- i_fu_data  in  DATA_W  functional unit result stream.
- o_we  out  NUM_VREG  one-hot write enable to the vector register file.
- o_waddr  out  ADDR_W  element address.
- o_wdata  out  DATA_W  write data.
- o_elem_count  out  VL_W  elements committed so far in the current operation (chain pointer).
- o_busy  out  1  high while the operation is outstanding.
- o_done  out  1  one-cycle pulse after the last write.
- o_start_ignored  out  1  one-cycle pulse when i_start arrives while busy.

Behaviour:
- Reset values (all outputs registered; all counters also cleared):
  - o_we = 0, o_waddr = 0, o_wdata = 0.
  - o_elem_count = 0, o_busy = 0, o_done = 0, o_start_ignored = 0.
  - State = IDLE.
- Operand normalisation at i_start:
  - eff_vl = 64 if i_vl == 0 or i_vl > 64, else i_vl.
  - eff_lat = 1 if i_latency == 0, else i_latency.
  - i_i, eff_vl and eff_lat are latched; later changes on these inputs have no effect.
- FSM states: IDLE, WAIT, WRITE.
- IDLE:
  - On i_start, go to WAIT with wait counter = eff_lat - 1.
  - o_busy rises the cycle after i_start.
  - o_elem_count clears to 0 at the same edge.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, go to WRITE; that cycle is T+eff_lat, where T is the i_start cycle.
  - With eff_lat = 1, WAIT lasts exactly one cycle.
- WRITE:
  - Element k is sampled from i_fu_data at the clock edge ending cycle T+eff_lat+k.
  - Element k is presented on o_we/o_waddr/o_wdata during cycle T+eff_lat+k+1.
  - o_waddr = k; o_we = one-hot(i_i latched).
  - o_elem_count = k+1 from that same cycle.
  - After element eff_vl-1 is sampled, return to IDLE. The final write is still presented the next cycle.
- Completion:
  - o_done pulses in the cycle after the final write cycle.
  - o_busy falls in that same cycle.
  - o_elem_count holds eff_vl until the next start.
- Between writes:
  - o_we = 0.
  - o_waddr and o_wdata hold their last values.
- Back-to-back: a new i_start is accepted in the same cycle o_done is high (state is IDLE).
- i_start while busy:
  - Dropped.
  - o_start_ignored pulses the next cycle.
  - The current operation is unaffected.
- Reset mid-operation:
  - Takes effect at the next edge.
  - No further writes; all outputs return to reset values.
  - o_done does not pulse.
- Widths:
  - The element counter is VL_W bits, so it never wraps at 64.
  - o_waddr = counter[ADDR_W-1:0], so element 63 writes address 63.
- Total busy span = eff_lat + eff_vl + 1 cycles. Issue logic uses this.

Decomposition:
- Shared package vector_pkg:
  - Constants MAX_VL = 64, DATA_W, NUM_VREG.
  - FSM state encoding for IDLE, WAIT, WRITE.
  - A function normalising a raw VL to eff_vl. It is reused by the read-side sequencers and the reservation logic.
- One natural sub-module: vreg_onehot_decode (3-bit register number to NUM_VREG-bit one-hot). Everything else stays in the top module.

Test Plan:
- Basic: start with i_vl=8, i_i=3, i_latency=4, i_fu_data = 0x100+n in cycle T+4+n.
  - o_we = 8'b00001000 for 8 consecutive cycles starting T+5.
  - o_waddr 0..7; o_wdata 0x100..0x107; o_elem_count 1..8.
  - o_done at T+13; o_busy high T+1..T+12.
- Normalisation: i_vl=0, i_latency=0 → 64 writes starting T+2, addresses 0..63; i_vl=100 also gives 64 writes; o_elem_count ends at 64.
- Busy start: second i_start at T+6 during the basic case → o_start_ignored at T+7; write sequence and o_done timing identical to the basic case.
- Back-to-back: second i_start (i_i=5, i_vl=2, i_latency=1) in the o_done cycle of the first → o_we = 8'b00100000 at addresses 0,1, two and three cycles later; no gap or overlap errors.
- Reset mid-op: assert rst at T+7 of the basic case → o_we = 0 from T+8 onward, no o_done, o_elem_count = 0; a fresh start afterwards behaves as the basic case.
- Input hold: change i_i, i_vl and i_latency every cycle after i_start → writes follow the latched values only.
